// File: rtl/board_flip_engine_pkg.sv
// Shared Othello definitions: cell encoding, FSM states, direction table and
// the opponent helper used by the move engine and its board store.
package othello_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SCAN  = 3'd2,
    FLIP  = 3'd3,
    NEXT  = 3'd4,
    PLACE = 3'd5,
    DONE  = 3'd6
  } state_e;

  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } dir_t;

  // Directions run clockwise from north: N, NE, E, SE, S, SW, W, NW.
  function automatic dir_t dir_step(input logic [2:0] d);
    dir_t r;
    case (d)
      3'd0:    begin r.dx = 2'sb00; r.dy = 2'sb11; end
      3'd1:    begin r.dx = 2'sb01; r.dy = 2'sb11; end
      3'd2:    begin r.dx = 2'sb01; r.dy = 2'sb00; end
      3'd3:    begin r.dx = 2'sb01; r.dy = 2'sb01; end
      3'd4:    begin r.dx = 2'sb00; r.dy = 2'sb01; end
      3'd5:    begin r.dx = 2'sb11; r.dy = 2'sb01; end
      3'd6:    begin r.dx = 2'sb11; r.dy = 2'sb00; end
      default: begin r.dx = 2'sb11; r.dy = 2'sb11; end
    endcase
    return r;
  endfunction

  function automatic logic [1:0] opponent(input logic [1:0] s);
    return (s == CELL_BLACK) ? CELL_WHITE : CELL_BLACK;
  endfunction

endpackage

// File: rtl/board_flip_engine_board_store.sv
// Board register array with init-on-reset/clear, one write port and two
// combinational read ports (engine and renderer).
module board_store
  import othello_pkg::*;
#(
  parameter int BOARD_N = 8,
  parameter int COORD_W = $clog2(BOARD_N)
) (
  input  logic               clock,
  input  logic               init_i,
  input  logic               we_i,
  input  logic [COORD_W-1:0] wx_i,
  input  logic [COORD_W-1:0] wy_i,
  input  logic [1:0]         wdata_i,
  input  logic [COORD_W-1:0] ax_i,
  input  logic [COORD_W-1:0] ay_i,
  output logic [1:0]         aq_o,
  input  logic [COORD_W-1:0] bx_i,
  input  logic [COORD_W-1:0] by_i,
  output logic [1:0]         bq_o
);

  localparam logic [COORD_W:0] LIM = (COORD_W + 1)'(BOARD_N);

  logic [1:0] cells_q [BOARD_N][BOARD_N];

  function automatic logic [1:0] init_cell(input int x, input int y);
    int c;
    c = BOARD_N / 2;
    if ((x == c - 1 && y == c - 1) || (x == c && y == c)) return CELL_WHITE;
    if ((x == c && y == c - 1) || (x == c - 1 && y == c)) return CELL_BLACK;
    return CELL_EMPTY;
  endfunction

  always_ff @(posedge clock) begin
    if (init_i) begin
      for (int y = 0; y < BOARD_N; y++) begin
        for (int x = 0; x < BOARD_N; x++) begin
          cells_q[y][x] <= init_cell(x, y);
        end
      end
    end else if (we_i) begin
      cells_q[wy_i][wx_i] <= wdata_i;
    end
  end

  // Coordinates beyond the edge (non power-of-two boards) read as empty.
  assign aq_o = (({1'b0, ax_i} < LIM) && ({1'b0, ay_i} < LIM)) ? cells_q[ay_i][ax_i] : CELL_EMPTY;
  assign bq_o = (({1'b0, bx_i} < LIM) && ({1'b0, by_i} < LIM)) ? cells_q[by_i][bx_i] : CELL_EMPTY;

endmodule

// File: rtl/board_flip_engine.sv
// Othello move engine: checks legality by scanning 8 directions, flips captured
// discs and streams every changed cell to the plot path. Optional: SCORE_EN.
module board_flip_engine
  import othello_pkg::*;
#(
  parameter int BOARD_N = 8,
  parameter int COORD_W = $clog2(BOARD_N),
  parameter int CNT_W   = $clog2(BOARD_N * BOARD_N + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               move_valid,
  input  logic [COORD_W-1:0] move_x,
  input  logic [COORD_W-1:0] move_y,
  input  logic [1:0]         side,
  output logic               busy,
  output logic               done,
  output logic               legal,
  output logic [CNT_W-1:0]   flip_count,
  output logic [7:0]         flip_dirs,
  output logic               plot_valid,
  input  logic               plot_ready,
  output logic [COORD_W-1:0] plot_x,
  output logic [COORD_W-1:0] plot_y,
  output logic [1:0]         plot_side,
  input  logic [COORD_W-1:0] rd_x,
  input  logic [COORD_W-1:0] rd_y,
  output logic [1:0]         rd_q,
  output logic [CNT_W-1:0]   count_black,
  output logic [CNT_W-1:0]   count_white
);

  typedef logic signed [COORD_W:0] scoord_t;
  localparam logic [COORD_W:0] LIM = (COORD_W + 1)'(BOARD_N);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] tx_q, tx_d, ty_q, ty_d;
  logic [1:0]         side_q, side_d;
  logic [2:0]         dir_q, dir_d;
  logic [COORD_W-1:0] run_q, run_d;
  scoord_t            cx_q, cx_d, cy_q, cy_d;
  logic               legal_q, legal_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic [7:0]         fdirs_q, fdirs_d;
  logic               pv_q, pv_d;
  logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
  logic [1:0]         ps_q, ps_d;

  logic               board_init;
  logic               we;
  logic [COORD_W-1:0] wx, wy, eng_x, eng_y;
  logic [1:0]         wdata, eng_q;
  logic [2:0]         nd;
  dir_t               nstep, cstep;
  scoord_t            tx_s, ty_s, sx, sy;
  logic               on_board;

  function automatic scoord_t sext(input logic signed [1:0] v);
    return {{(COORD_W - 1){v[1]}}, v};
  endfunction

  assign board_init = reset || (clear && state_q == IDLE);

  board_store #(.BOARD_N(BOARD_N), .COORD_W(COORD_W)) u_store (
    .clock   (clock),
    .init_i  (board_init),
    .we_i    (we),
    .wx_i    (wx),
    .wy_i    (wy),
    .wdata_i (wdata),
    .ax_i    (eng_x),
    .ay_i    (eng_y),
    .aq_o    (eng_q),
    .bx_i    (rd_x),
    .by_i    (rd_y),
    .bq_o    (rd_q)
  );

  // nd is the direction whose walk starts next; sx/sy is its first cell.
  assign nd    = (state_q == CHECK) ? 3'd0 : (state_q == NEXT) ? dir_q + 3'd1 : dir_q;
  assign nstep = dir_step(nd);
  assign cstep = dir_step(dir_q);
  assign tx_s  = {1'b0, tx_q};
  assign ty_s  = {1'b0, ty_q};
  assign sx    = tx_s + sext(nstep.dx);
  assign sy    = ty_s + sext(nstep.dy);

  // A negative sign bit covers both -1 and the wrapped value one past the edge.
  assign on_board = !cx_q[COORD_W] && !cy_q[COORD_W] &&
                    ({1'b0, cx_q[COORD_W-1:0]} < LIM) && ({1'b0, cy_q[COORD_W-1:0]} < LIM);

  assign eng_x = (state_q == CHECK) ? tx_q : cx_q[COORD_W-1:0];
  assign eng_y = (state_q == CHECK) ? ty_q : cy_q[COORD_W-1:0];

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    side_d  = side_q;
    dir_d   = dir_q;
    run_d   = run_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    legal_d = legal_q;
    fcnt_d  = fcnt_q;
    fdirs_d = fdirs_q;
    pv_d    = pv_q;
    px_d    = px_q;
    py_d    = py_q;
    ps_d    = ps_q;
    we      = 1'b0;
    wx      = tx_q;
    wy      = ty_q;
    wdata   = side_q;
    case (state_q)
      IDLE: begin
        if (!clear && move_valid) begin
          tx_d    = move_x;
          ty_d    = move_y;
          side_d  = side;
          legal_d = 1'b0;
          fcnt_d  = '0;
          fdirs_d = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (eng_q != CELL_EMPTY) begin
          state_d = DONE;
        end else begin
          dir_d   = 3'd0;
          cx_d    = sx;
          cy_d    = sy;
          run_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!on_board || eng_q == CELL_EMPTY) begin
          state_d = NEXT;
        end else if (eng_q == side_q) begin
          if (run_q != '0) begin
            fdirs_d[dir_q] = 1'b1;
            cx_d           = sx;
            cy_d           = sy;
            state_d        = FLIP;
          end else begin
            state_d = NEXT;
          end
        end else if (eng_q == opponent(side_q)) begin
          run_d = run_q + COORD_W'(1);
          cx_d  = cx_q + sext(cstep.dx);
          cy_d  = cy_q + sext(cstep.dy);
        end else begin
          state_d = NEXT;
        end
      end
      FLIP: begin
        // Each captured cell: write and raise plot, then step once it transfers.
        if (!pv_q) begin
          we     = 1'b1;
          wx     = cx_q[COORD_W-1:0];
          wy     = cy_q[COORD_W-1:0];
          pv_d   = 1'b1;
          px_d   = cx_q[COORD_W-1:0];
          py_d   = cy_q[COORD_W-1:0];
          ps_d   = side_q;
          fcnt_d = fcnt_q + CNT_W'(1);
        end else if (plot_ready) begin
          pv_d  = 1'b0;
          run_d = run_q - COORD_W'(1);
          cx_d  = cx_q + sext(cstep.dx);
          cy_d  = cy_q + sext(cstep.dy);
          if (run_q == COORD_W'(1)) state_d = NEXT;
        end
      end
      NEXT: begin
        if (dir_q == 3'd7) begin
          state_d = PLACE;
        end else begin
          dir_d   = nd;
          cx_d    = sx;
          cy_d    = sy;
          run_d   = '0;
          state_d = SCAN;
        end
      end
      PLACE: begin
        if (fcnt_q == '0) begin
          state_d = DONE;
        end else if (!pv_q) begin
          we   = 1'b1;
          pv_d = 1'b1;
          px_d = tx_q;
          py_d = ty_q;
          ps_d = side_q;
        end else if (plot_ready) begin
          pv_d    = 1'b0;
          legal_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      legal_q <= 1'b0;
      fcnt_q  <= '0;
      fdirs_q <= '0;
      pv_q    <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      ps_q    <= '0;
    end else begin
      state_q <= state_d;
      legal_q <= legal_d;
      fcnt_q  <= fcnt_d;
      fdirs_q <= fdirs_d;
      pv_q    <= pv_d;
      px_q    <= px_d;
      py_q    <= py_d;
      ps_q    <= ps_d;
    end
  end

  always_ff @(posedge clock) begin
    tx_q   <= tx_d;
    ty_q   <= ty_d;
    side_q <= side_d;
    dir_q  <= dir_d;
    run_q  <= run_d;
    cx_q   <= cx_d;
    cy_q   <= cy_d;
  end

`ifdef SCORE_EN
  logic             flip_we, place_we;
  logic [CNT_W-1:0] cb_q, cw_q;

  assign flip_we  = we && (state_q == FLIP);
  assign place_we = we && (state_q == PLACE);

  always_ff @(posedge clock) begin
    if (board_init) begin
      cb_q <= CNT_W'(2);
      cw_q <= CNT_W'(2);
    end else if (flip_we || place_we) begin
      if (side_q == CELL_BLACK) begin
        cb_q <= cb_q + CNT_W'(1);
        if (flip_we) cw_q <= cw_q - CNT_W'(1);
      end else begin
        cw_q <= cw_q + CNT_W'(1);
        if (flip_we) cb_q <= cb_q - CNT_W'(1);
      end
    end
  end

  assign count_black = cb_q;
  assign count_white = cw_q;
`else
  assign count_black = '0;
  assign count_white = '0;
`endif

  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign done       = (state_q == DONE);
  assign legal      = legal_q;
  assign flip_count = fcnt_q;
  assign flip_dirs  = fdirs_q;
  assign plot_valid = pv_q;
  assign plot_x     = px_q;
  assign plot_y     = py_q;
  assign plot_side  = ps_q;

endmodule

// File: tb/tb_board_flip_engine.sv
// Bench for board_flip_engine (BOARD_N=8): table of moves from the init board,
// a plot scoreboard queue, and hand sequences for stall, reset and busy cases.
module tb_board_flip_engine;

  localparam int N    = 8;
  localparam int CW   = 3;
  localparam int CNTW = 7;
`ifdef SCORE_EN
  localparam int SCORE_MUL = 1;
`else
  localparam int SCORE_MUL = 0;
`endif

  logic            clock = 1'b0;
  logic            reset, clear, move_valid, plot_ready;
  logic [CW-1:0]   move_x, move_y, rd_x, rd_y;
  logic [1:0]      side;
  logic            busy, done, legal, plot_valid;
  logic [CNTW-1:0] flip_count, count_black, count_white;
  logic [7:0]      flip_dirs;
  logic [CW-1:0]   plot_x, plot_y;
  logic [1:0]      plot_side, rd_q;

  board_flip_engine #(.BOARD_N(N)) dut (
    .clock(clock), .reset(reset), .clear(clear), .move_valid(move_valid),
    .move_x(move_x), .move_y(move_y), .side(side), .busy(busy), .done(done),
    .legal(legal), .flip_count(flip_count), .flip_dirs(flip_dirs),
    .plot_valid(plot_valid), .plot_ready(plot_ready), .plot_x(plot_x),
    .plot_y(plot_y), .plot_side(plot_side), .rd_x(rd_x), .rd_y(rd_y),
    .rd_q(rd_q), .count_black(count_black), .count_white(count_white)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         x;
    int         y;
    logic [1:0] s;
  } plot_t;

  typedef struct {
    int         mx;
    int         my;
    logic [1:0] s;
    int         stall;
    int         legal;
    int         fc;
    int         dirs;
    int         lat;
    int         np;
    plot_t      p0;
    plot_t      p1;
    int         cb;
    int         cw;
    int         tgt;
  } vec_t;

  plot_t exp_q[$];
  plot_t mon_e;
  vec_t  vecs[7];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic int sc(input int v);
    return v * SCORE_MUL;
  endfunction

  task automatic cell_chk(input string name, input int x, input int y, input int e);
    rd_x = CW'(x);
    rd_y = CW'(y);
    #1;
    chk(name, int'(rd_q), e);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    clear      = 1'b0;
    move_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic drive_move(input int x, input int y, input logic [1:0] s);
    move_x     = CW'(x);
    move_y     = CW'(y);
    side       = s;
    move_valid = 1'b1;
    @(posedge clock); #1;
    move_valid = 1'b0;
  endtask

  // Scoreboard: every plot transfer must match the next expected cell.
  always @(negedge clock) begin
    if (!reset && plot_valid && plot_ready) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL plot_unexpected: got (%0d,%0d,%0d), required no plot", plot_x, plot_y, plot_side);
      end else begin
        mon_e = exp_q.pop_front();
        chk("plot_x", int'(plot_x), mon_e.x);
        chk("plot_y", int'(plot_y), mon_e.y);
        chk("plot_side", int'(plot_side), int'(mon_e.s));
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int         lat, stall_left;
    bit         held;
    logic [2:0] hx, hy;
    logic [1:0] hs;
    logic       rdy_next;
    do_reset();
    if (v.np > 0) exp_q.push_back(v.p0);
    if (v.np > 1) exp_q.push_back(v.p1);
    plot_ready = (v.stall == 0);
    drive_move(v.mx, v.my, v.s);
    stall_left = v.stall;
    held       = 1'b0;
    lat        = 0;
    hx = '0; hy = '0; hs = '0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clock);
      if (done) begin
        lat = n;
        break;
      end
      rdy_next = plot_ready;
      if (plot_valid && stall_left > 0) begin
        if (held) begin
          chk("stall_plot_x", int'(plot_x), int'(hx));
          chk("stall_plot_y", int'(plot_y), int'(hy));
          chk("stall_plot_side", int'(plot_side), int'(hs));
        end else begin
          hx = plot_x; hy = plot_y; hs = plot_side;
          held = 1'b1;
          chk("stall_first_x", int'(plot_x), v.p0.x);
          chk("stall_first_y", int'(plot_y), v.p0.y);
        end
        chk("stall_busy", int'(busy), 1);
        stall_left--;
        if (stall_left == 0) rdy_next = 1'b1;
      end
      @(posedge clock); #1;
      plot_ready = rdy_next;
    end
    chk("done_seen", int'(lat != 0), 1);
    if (v.lat != 0) chk("done_latency", lat, v.lat);
    chk("busy_at_done", int'(busy), 0);
    chk("legal", int'(legal), v.legal);
    chk("flip_count", int'(flip_count), v.fc);
    chk("flip_dirs", int'(flip_dirs), v.dirs);
    chk("count_black", int'(count_black), sc(v.cb));
    chk("count_white", int'(count_white), sc(v.cw));
    chk("plots_pending", exp_q.size(), 0);
    cell_chk("target_cell", v.mx, v.my, v.tgt);
    @(posedge clock); #1;
    @(negedge clock);
    chk("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    int  dones, first;
    bit  got;
    reset = 1'b1; clear = 1'b0; move_valid = 1'b0; plot_ready = 1'b1;
    move_x = '0; move_y = '0; side = 2'b01; rd_x = '0; rd_y = '0;

    vecs[0] = '{mx:2, my:3, s:2'b01, stall:0, legal:1, fc:1, dirs:8'h04, lat:0, np:2,
                p0:'{3, 3, 2'b01}, p1:'{2, 3, 2'b01}, cb:4, cw:1, tgt:1};
    vecs[1] = '{mx:3, my:3, s:2'b01, stall:0, legal:0, fc:0, dirs:0, lat:2, np:0,
                p0:'{0, 0, 2'b00}, p1:'{0, 0, 2'b00}, cb:2, cw:2, tgt:2};
    vecs[2] = '{mx:0, my:0, s:2'b01, stall:0, legal:0, fc:0, dirs:0, lat:19, np:0,
                p0:'{0, 0, 2'b00}, p1:'{0, 0, 2'b00}, cb:2, cw:2, tgt:0};
    vecs[3] = '{mx:2, my:2, s:2'b01, stall:0, legal:0, fc:0, dirs:0, lat:21, np:0,
                p0:'{0, 0, 2'b00}, p1:'{0, 0, 2'b00}, cb:2, cw:2, tgt:0};
    vecs[4] = '{mx:4, my:2, s:2'b10, stall:0, legal:1, fc:1, dirs:8'h10, lat:0, np:2,
                p0:'{4, 3, 2'b10}, p1:'{4, 2, 2'b10}, cb:1, cw:4, tgt:2};
    vecs[5] = '{mx:5, my:4, s:2'b01, stall:0, legal:1, fc:1, dirs:8'h40, lat:0, np:2,
                p0:'{4, 4, 2'b01}, p1:'{5, 4, 2'b01}, cb:4, cw:1, tgt:1};
    vecs[6] = '{mx:2, my:3, s:2'b01, stall:5, legal:1, fc:1, dirs:8'h04, lat:0, np:2,
                p0:'{3, 3, 2'b01}, p1:'{2, 3, 2'b01}, cb:4, cw:1, tgt:1};

    // Reset state
    do_reset();
    @(negedge clock);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_legal", int'(legal), 0);
    chk("rst_flip_count", int'(flip_count), 0);
    chk("rst_flip_dirs", int'(flip_dirs), 0);
    chk("rst_plot_valid", int'(plot_valid), 0);
    chk("rst_plot_xy", int'({plot_x, plot_y, plot_side}), 0);
    chk("rst_count_black", int'(count_black), sc(2));
    chk("rst_count_white", int'(count_white), sc(2));
    cell_chk("rst_cell_33", 3, 3, 2);
    cell_chk("rst_cell_44", 4, 4, 2);
    cell_chk("rst_cell_43", 4, 3, 1);
    cell_chk("rst_cell_34", 3, 4, 1);
    cell_chk("rst_cell_00", 0, 0, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Clear in IDLE restores the init board; clear beats a simultaneous move
    run_vec(vecs[0]);
    @(posedge clock); #1;
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    @(negedge clock);
    cell_chk("clr_cell_33", 3, 3, 2);
    cell_chk("clr_cell_23", 2, 3, 0);
    chk("clr_count_black", int'(count_black), sc(2));
    chk("clr_count_white", int'(count_white), sc(2));
    @(posedge clock); #1;
    clear = 1'b1;
    move_x = 3'd2; move_y = 3'd3; side = 2'b01; move_valid = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0; move_valid = 1'b0;
    @(negedge clock);
    chk("clr_wins_busy", int'(busy), 0);

    // Reset during FLIP aborts the move and restores the board
    do_reset();
    plot_ready = 1'b0;
    drive_move(2, 3, 2'b01);
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (plot_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("flip_reached", int'(got), 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("abort_busy", int'(busy), 0);
    chk("abort_plot_valid", int'(plot_valid), 0);
    cell_chk("abort_cell_33", 3, 3, 2);
    cell_chk("abort_cell_23", 2, 3, 0);
    chk("abort_count_black", int'(count_black), sc(2));
    @(posedge clock); #1;
    reset = 1'b0;
    plot_ready = 1'b1;
    exp_q.delete();

    // Requests while busy are dropped, not queued
    do_reset();
    plot_ready = 1'b1;
    drive_move(0, 0, 2'b01);
    dones = 0;
    first = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (done) begin
        dones++;
        if (first == 0) first = n;
      end
      @(posedge clock); #1;
      if (n == 3) begin
        move_x = 3'd2; move_y = 3'd3; side = 2'b01;
        move_valid = 1'b1; clear = 1'b1;
      end else begin
        move_valid = 1'b0; clear = 1'b0;
      end
    end
    chk("busy_ignore_dones", dones, 1);
    chk("busy_ignore_latency", first, 19);
    cell_chk("busy_ignore_cell_23", 2, 3, 0);
    chk("busy_ignore_plots", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
